synchronizer: RTL and testbench
===============================

SYNCHRONIZER -- requirements
Module: synchronizer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop stages per chain; legal values 2..4.
REQ-002 clock  input  1  sole clock; every flop in the block triggers on its rising edge.
REQ-003 Reset  input  1  one clock; reset is asynchronous and active-high; also the raw reset that gets synchronized.
REQ-004 Sensor  input  1  asynchronous vehicle sensor, active-high level.
REQ-005 Walk_Request  input  1  asynchronous pedestrian button, active-high.
REQ-006 Reprogram  input  1  asynchronous reprogram button, active-high.
REQ-007 Reset_Sync  output  1  synchronized reset: asserts asynchronously, deasserts synchronously.
REQ-008 Sensor_Sync  output  1  Sensor after the SYNC_STAGES-flop chain.
REQ-009 WR_Sync  output  1  Walk_Request after the SYNC_STAGES-flop chain.
REQ-010 Prog_Sync  output  1  Reprogram after the SYNC_STAGES-flop chain.

Function
REQ-011 Four independent chains, each SYNC_STAGES flops in series; output = last flop; no combinational logic between stages or after the last stage.
REQ-012 Sensor, Walk_Request and Reprogram chains: stage 1 samples the raw input; stage n samples stage n-1.
REQ-013 Data latency: a level stable across a rising edge at which stage 1 captures it appears at the output SYNC_STAGES edges later, e.g. 2 edges at default.
REQ-014 No pulse stretching or edge detection: inputs narrower than one clock period may be lost; held levels pass through unchanged.
REQ-015 Reset chain: stage 1 samples constant 0; stage n samples stage n-1; Reset_Sync = last stage.
REQ-016 Reset_Sync deassertion: Reset falls between edges -> Reset_Sync falls on the SYNC_STAGES-th subsequent rising edge, e.g. 2nd at default.
REQ-017 Simultaneous events: an input and Reset changing in the same instant -> reset wins; the data chain stays cleared while Reset is high.
REQ-018 Reset mid-operation: Reset rising at any time clears all data chains and sets all reset-chain flops immediately, with no clock required.
REQ-019 Re-assertion of Reset during a Reset_Sync deassertion countdown restarts the full SYNC_STAGES countdown.
REQ-020 Outputs hold their values indefinitely absent clock edges and input changes.

Reset
REQ-021 Reset=1 drives Reset_Sync=1 and Sensor_Sync=WR_Sync=Prog_Sync=0 asynchronously, within the same delta cycle, independent of clock.
REQ-022 All data-chain flops clear to 0; all reset-chain flops set to 1.
REQ-023 After power-up with Reset held, outputs are defined before the first clock edge.
REQ-024 Data chains leave reset when Reset falls; Reset_Sync lags per REQ-016.

Verification
Clock period 20 ns with first rising edge at 10 ns (clock low at t=0, toggled every 10 ns); all times in ns.
REQ-025 All four inputs = 1 at t=0, all drop at t=15 -> Reset_Sync=1 from t=0; other outputs 0 throughout; Reset_Sync falls at t=50 (2nd edge after 15).
REQ-026 Reset low, Sensor rises at t=95, held -> Sensor_Sync=0 after edge 110, =1 after edge 130; WR_Sync and Prog_Sync remain 0.
REQ-027 Walk_Request pulse 12..16 (no edge in window) -> WR_Sync stays 0; pulse 105..135 -> WR_Sync=1 from edge 130 to edge 170.
REQ-028 Reprogram=1 and Sensor=1 steady, outputs 1; Reset pulse 203..207 -> Prog_Sync=Sensor_Sync=0 and Reset_Sync=1 at t=203; Reset_Sync falls at edge 230; data outputs return to 1 at edge 230.
REQ-029 Reset rises at 215 and falls at 217 with Reset_Sync still 1 from REQ-028 -> Reset_Sync falls at edge 250, not edge 230.
REQ-030 With SYNC_STAGES=3, repeat REQ-025 and REQ-026 -> Reset_Sync falls at t=70; Sensor_Sync rises at edge 150.

Source files
------------

// File: rtl/synchronizer.sv
// Brings the raw reset and three asynchronous button/sensor inputs into the clock domain.
// The reset chain asserts asynchronously and releases only after SYNC_STAGES clean edges.
`timescale 1ns/1ps
module synchronizer #(
    parameter int SYNC_STAGES = 2  // legal range 2..4
) (
    input  logic clock,
    input  logic Reset,
    input  logic Sensor,
    input  logic Walk_Request,
    input  logic Reprogram,
    output logic Reset_Sync,
    output logic Sensor_Sync,
    output logic WR_Sync,
    output logic Prog_Sync
);

    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] sensor_chain;
    logic [SYNC_STAGES-1:0] wr_chain;
    logic [SYNC_STAGES-1:0] prog_chain;

    // Bit 0 is stage 1; each edge shifts toward the MSB, which drives the output.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            rst_chain <= '1;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            sensor_chain <= '0;
            wr_chain     <= '0;
            prog_chain   <= '0;
        end else begin
            sensor_chain <= {sensor_chain[SYNC_STAGES-2:0], Sensor};
            wr_chain     <= {wr_chain[SYNC_STAGES-2:0], Walk_Request};
            prog_chain   <= {prog_chain[SYNC_STAGES-2:0], Reprogram};
        end
    end

    // Outputs come straight off the last flop of each chain.
    assign Reset_Sync  = rst_chain[SYNC_STAGES-1];
    assign Sensor_Sync = sensor_chain[SYNC_STAGES-1];
    assign WR_Sync     = wr_chain[SYNC_STAGES-1];
    assign Prog_Sync   = prog_chain[SYNC_STAGES-1];

endmodule

// File: tb/tb_synchronizer.sv
// Directed timeline check of two synchronizer instances (2 and 3 stages) sharing one set of inputs.
// Clock period 20 ns, rising edges at 10, 30, 50, ...
`timescale 1ns/1ps
module tb_synchronizer;

    logic clock;
    logic Reset;
    logic Sensor;
    logic Walk_Request;
    logic Reprogram;

    logic rs2, ss2, wr2, ps2;
    logic rs3, ss3, wr3, ps3;

    int n_checks;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    synchronizer #(.SYNC_STAGES(2)) dut2 (
        .clock        (clock),
        .Reset        (Reset),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .Reprogram    (Reprogram),
        .Reset_Sync   (rs2),
        .Sensor_Sync  (ss2),
        .WR_Sync      (wr2),
        .Prog_Sync    (ps2)
    );

    synchronizer #(.SYNC_STAGES(3)) dut3 (
        .clock        (clock),
        .Reset        (Reset),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .Reprogram    (Reprogram),
        .Reset_Sync   (rs3),
        .Sensor_Sync  (ss3),
        .WR_Sync      (wr3),
        .Prog_Sync    (ps3)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic at_time(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at t=%0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all2(input string tag, input logic r, input logic s,
                              input logic w, input logic p);
        check({tag, " rs2"}, rs2, r);
        check({tag, " ss2"}, ss2, s);
        check({tag, " wr2"}, wr2, w);
        check({tag, " ps2"}, ps2, p);
    endtask

    task automatic check_all3(input string tag, input logic r, input logic s,
                              input logic w, input logic p);
        check({tag, " rs3"}, rs3, r);
        check({tag, " ss3"}, ss3, s);
        check({tag, " wr3"}, wr3, w);
        check({tag, " ps3"}, ps3, p);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Power-up with reset and all inputs high: outputs defined before first edge
        Reset = 1'b1; Sensor = 1'b1; Walk_Request = 1'b1; Reprogram = 1'b1;
        at_time(1);
        check_all2("powerup", 1'b1, 1'b0, 1'b0, 1'b0);
        check_all3("powerup", 1'b1, 1'b0, 1'b0, 1'b0);

        at_time(15);
        Reset = 1'b0; Sensor = 1'b0; Walk_Request = 1'b0; Reprogram = 1'b0;

        at_time(35);
        check_all2("release_e30", 1'b1, 1'b0, 1'b0, 1'b0);
        check_all3("release_e30", 1'b1, 1'b0, 1'b0, 1'b0);
        at_time(45);
        check("release_pre50 rs2", rs2, 1'b1);
        at_time(55);
        check_all2("release_e50", 1'b0, 1'b0, 1'b0, 1'b0);
        check("release_e50 rs3", rs3, 1'b1);
        at_time(65);
        check("release_pre70 rs3", rs3, 1'b1);
        at_time(75);
        check_all3("release_e70", 1'b0, 1'b0, 1'b0, 1'b0);

        // Sensor rises at 95 and holds; Walk_Request pulse 105..135
        at_time(95);
        Sensor = 1'b1;
        at_time(105);
        Walk_Request = 1'b1;
        at_time(115);
        check("sensor_e110 ss2", ss2, 1'b0);
        check("wr_e110 wr2", wr2, 1'b0);
        at_time(135);
        Walk_Request = 1'b0;
        check("sensor_e130 ss2", ss2, 1'b1);
        check("sensor_e130 ss3", ss3, 1'b0);
        check("wr_e130 wr2", wr2, 1'b1);
        check("wr_e130 ps2", ps2, 1'b0);

        // Reprogram rises at 140 and holds
        at_time(140);
        Reprogram = 1'b1;
        at_time(155);
        check("sensor_e150 ss3", ss3, 1'b1);
        check("wr_e150 wr3", wr3, 1'b1);
        at_time(165);
        check("wr_pre170 wr2", wr2, 1'b1);
        check("prog_pre170 ps2", ps2, 1'b0);

        // Narrow Walk_Request pulse with no edge inside: must be lost
        at_time(172);
        Walk_Request = 1'b1;
        at_time(175);
        check("wr_e170 wr2", wr2, 1'b0);
        check("prog_e170 ps2", ps2, 1'b1);
        at_time(176);
        Walk_Request = 1'b0;
        at_time(200);
        check_all2("steady", 1'b0, 1'b1, 1'b0, 1'b1);
        check_all3("steady", 1'b0, 1'b1, 1'b0, 1'b1);

        // Short reset pulse 203..207 mid-operation, no clock inside
        at_time(203);
        Reset = 1'b1;
        at_time(204);
        check_all2("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
        check_all3("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
        at_time(207);
        Reset = 1'b0;
        at_time(225);
        check_all2("midreset_e210", 1'b1, 1'b0, 1'b0, 1'b0);
        at_time(235);
        check_all2("midreset_e230", 1'b0, 1'b1, 1'b0, 1'b1);
        check("midreset_e230 rs3", rs3, 1'b1);
        check("midreset_e230 ss3", ss3, 1'b0);
        at_time(255);
        check_all3("midreset_e250", 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset and Walk_Request rise together: reset wins
        at_time(303);
        Reset = 1'b1;
        Walk_Request = 1'b1;
        at_time(304);
        check_all2("simul", 1'b1, 1'b0, 1'b0, 1'b0);
        at_time(307);
        Reset = 1'b0;
        at_time(312);
        check("countdown_e310 rs2", rs2, 1'b1);

        // Re-assert during the countdown: full countdown restarts from 317
        at_time(315);
        Reset = 1'b1;
        at_time(316);
        check_all2("reassert", 1'b1, 1'b0, 1'b0, 1'b0);
        check_all3("reassert", 1'b1, 1'b0, 1'b0, 1'b0);
        at_time(317);
        Reset = 1'b0;
        at_time(335);
        check("reassert_e330 rs2", rs2, 1'b1);
        at_time(345);
        check("reassert_pre350 rs2", rs2, 1'b1);
        check("reassert_pre350 wr2", wr2, 1'b0);
        at_time(355);
        check_all2("reassert_e350", 1'b0, 1'b1, 1'b1, 1'b1);
        check("reassert_e350 rs3", rs3, 1'b1);
        at_time(365);
        check("reassert_pre370 rs3", rs3, 1'b1);
        at_time(375);
        check_all3("reassert_e370", 1'b0, 1'b1, 1'b1, 1'b1);

        // Held levels pass through unchanged
        at_time(415);
        check_all2("hold", 1'b0, 1'b1, 1'b1, 1'b1);
        check_all3("hold", 1'b0, 1'b1, 1'b1, 1'b1);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
